// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RISC-V load/store
// funct3 encodings and the responder state encoding.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Loads accept the signed and unsigned byte/halfword forms and LW; stores
  // accept only SB/SH/SW.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the responder: store byte-enables and replicated
// write data, load extraction with sign/zero extension, and access checks.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        bad
);

  logic [3:0]  be_raw_s;
  logic [31:0] rdata_raw_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        sext_s;
  logic        misalign_s;

  // Lane selection and extension; data is replicated across lanes so the
  // byte-enables alone decide which lanes change.
  always_comb begin
    be_raw_s    = 4'b0000;
    wword       = 32'h0000_0000;
    rdata_raw_s = 32'h0000_0000;
    misalign_s  = 1'b0;
    byte_s      = 8'(rword >> {addr_lo, 3'b000});
    half_s      = addr_lo[1] ? rword[31:16] : rword[15:0];
    sext_s      = ~funct3[2];
    case (funct3)
      F3_B, F3_BU: begin
        be_raw_s    = 4'b0001 << addr_lo;
        wword       = {4{wdata[7:0]}};
        rdata_raw_s = {{24{sext_s & byte_s[7]}}, byte_s};
      end
      F3_H, F3_HU: begin
        misalign_s  = addr_lo[0];
        be_raw_s    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword       = {2{wdata[15:0]}};
        rdata_raw_s = {{16{sext_s & half_s[15]}}, half_s};
      end
      F3_W: begin
        misalign_s  = (addr_lo != 2'b00);
        be_raw_s    = 4'b1111;
        wword       = wdata;
        rdata_raw_s = rword;
      end
      default: begin
        misalign_s  = 1'b0;
      end
    endcase
  end

  assign bad   = misalign_s | ~f3_legal(we, funct3);
  assign be    = bad ? 4'b0000 : be_raw_s;
  assign rdata = bad ? 32'h0000_0000 : rdata_raw_s;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a
// time, WAIT_CYCLES busy cycles, then a single-cycle response strobe.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state_r;
  state_t state_nxt_s;
  logic [3:0]  cnt_r;
  logic        ready_r;
  logic        rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;

  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  f3_r;

  logic [31:0] mem_r [DEPTH_WORDS];

  logic             accept_s;
  logic             enter_resp_s;
  logic             op_we_s;
  logic [31:0]      op_addr_s;
  logic [31:0]      op_wdata_s;
  logic [2:0]       op_f3_s;
  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      rword_s;
  logic [3:0]       be_s;
  logic [31:0]      wword_s;
  logic [31:0]      ld_s;
  logic             bad_s;
  logic             err_s;

  assign req_ready = ready_r & ~rst;
  assign accept_s  = req_valid & req_ready;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  // With no wait states RESP is entered straight from the accept edge, so the
  // operation is taken from the live request while still in IDLE.
  assign op_we_s    = (state_r == IDLE) ? req_we     : we_r;
  assign op_addr_s  = (state_r == IDLE) ? req_addr   : addr_r;
  assign op_wdata_s = (state_r == IDLE) ? req_wdata  : wdata_r;
  assign op_f3_s    = (state_r == IDLE) ? req_funct3 : f3_r;

  assign in_range_s = ({2'b00, op_addr_s[31:2]} < 32'(DEPTH_WORDS));
  assign idx_s      = op_addr_s[IDX_W+1:2];
  assign rword_s    = in_range_s ? mem_r[idx_s] : 32'h0000_0000;
  assign err_s      = bad_s | ~in_range_s;

  dmem_lane_align u_lane_align (
    .we      (op_we_s),
    .funct3  (op_f3_s),
    .addr_lo (op_addr_s[1:0]),
    .wdata   (op_wdata_s),
    .rword   (rword_s),
    .be      (be_s),
    .wword   (wword_s),
    .rdata   (ld_s),
    .bad     (bad_s)
  );

  // Next-state logic for the IDLE -> BUSY -> RESP -> IDLE sequence.
  always_comb begin
    state_nxt_s  = state_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt_s  = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_nxt_s  = BUSY;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s  = RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_nxt_s  = BUSY;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      ready_r     <= (state_nxt_s == IDLE);
      rsp_valid_r <= enter_resp_s;
      if (accept_s) begin
        cnt_r <= CNT_INIT;
      end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (enter_resp_s) begin
        rsp_err_r   <= err_s;
        rsp_rdata_r <= (err_s | op_we_s) ? 32'h0000_0000 : ld_s;
      end else begin
        rsp_err_r   <= rsp_err_r;
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

  // Request fields captured at accept; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      we_r    <= req_we;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      f3_r    <= req_funct3;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      f3_r    <= f3_r;
    end
  end

  // Storage write commits on the edge entering RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (enter_resp_s && !rst && op_we_s && !err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[idx_s][8*b +: 8] <= wword_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: one responder with two wait states and one with none,
// driven by a directed plan plus random traffic against a byte-level model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        req_ready  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] mm [2][DEPTH*4];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] erd;
    logic        eer;
  } vec_t;
  vec_t plan [16];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, access rules applied with plain arithmetic.
  task automatic model(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output logic [31:0] rd, output logic er);
    int     size;
    int     a;
    longint v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    er = 1'b0;
    rd = 32'h0;
    if (size == 0) er = 1'b1;
    if (we && f3 > 3'd2) er = 1'b1;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) er = 1'b1;
    if (size > 0 && (addr % size) != 0) er = 1'b1;
    if ((addr / 4) >= DEPTH) er = 1'b1;
    if (er) return;
    a = int'(addr);
    if (we) begin
      for (int k = 0; k < size; k++) mm[i][a+k] = 8'(wd >> (8*k));
    end else begin
      v = 0;
      for (int k = 0; k < size; k++) v = v + (longint'(mm[i][a+k]) << (8*k));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1)))
        v = v - (longint'(1) << (8*size));
      rd = 32'(v);
    end
  endtask

  // One complete transaction, entered and left at a falling edge.
  task automatic do_req(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er);
    int   n;
    logic rdy_seen;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 50), 32'd1);
    req_valid[i]  = 1'b1;
    req_we[i]     = we;
    req_addr[i]   = addr;
    req_wdata[i]  = wd;
    req_funct3[i] = f3;
    @(negedge clk);
    req_valid[i] = 1'b0;
    n = 1;
    rdy_seen = 1'b0;
    while (!rsp_valid[i] && n < 40) begin
      if (req_ready[i]) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    if (req_ready[i]) rdy_seen = 1'b1;
    check("latency", 32'(n), 32'(wait_of(i) + 1));
    check("ready_low_busy", 32'(rdy_seen), 32'd0);
    rd = rsp_rdata[i];
    er = rsp_err[i];
    @(negedge clk);
    check("strobe_len", 32'(rsp_valid[i]), 32'd0);
  endtask

  task automatic run_model(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] erd, rd;
    logic        eer, er;
    model(i, we, addr, wd, f3, erd, eer);
    do_req(i, we, addr, wd, f3, rd, er);
    check("rdata", rd, erd);
    check("err", 32'(er), 32'(eer));
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] tmp_rd;
    logic        er;
    logic        tmp_er;
    int          acc [2];
    int          na;
    int          nr;
    int          back;
    logic        seen;

    plan = '{
      '{1'b1, 32'h10,  32'hDEADBEEF, F3_W,  32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        F3_W,  32'hDEADBEEF, 1'b0},
      '{1'b1, 32'h13,  32'h80,       F3_B,  32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        F3_W,  32'h80ADBEEF, 1'b0},
      '{1'b0, 32'h13,  32'h0,        F3_B,  32'hFFFFFF80, 1'b0},
      '{1'b0, 32'h13,  32'h0,        F3_BU, 32'h00000080, 1'b0},
      '{1'b0, 32'h12,  32'h0,        F3_H,  32'hFFFF80AD, 1'b0},
      '{1'b0, 32'h10,  32'h0,        F3_HU, 32'h0000BEEF, 1'b0},
      '{1'b0, 32'h11,  32'h0,        F3_H,  32'h0,        1'b1},
      '{1'b1, 32'h12,  32'h11111111, F3_W,  32'h0,        1'b1},
      '{1'b0, 32'h10,  32'h0,        F3_W,  32'h80ADBEEF, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,       1'b1},
      '{1'b0, 32'h400, 32'h0,        F3_W,  32'h0,        1'b1},
      '{1'b1, 32'h10,  32'hFFFFFFFF, 3'b011, 32'h0,       1'b1},
      '{1'b1, 32'h10,  32'hFFFFFFFF, F3_BU, 32'h0,        1'b1},
      '{1'b0, 32'h10,  32'h0,        F3_W,  32'h80ADBEEF, 1'b0}
    };

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; req_funct3[i] = 3'b000;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_err",   32'(rsp_err[i]),   32'd0);
      check("rst_rdata", rsp_rdata[i],      32'h0);
      check("rst_ready", 32'(req_ready[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) check("ready_after_rst", 32'(req_ready[i]), 32'd1);

    // Directed plan on both wait-state settings.
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 16; p++) begin
        model(i, plan[p].we, plan[p].addr, plan[p].wd, plan[p].f3, tmp_rd, tmp_er);
        do_req(i, plan[p].we, plan[p].addr, plan[p].wd, plan[p].f3, rd, er);
        check($sformatf("plan%0d_%0d_rdata", i, p), rd, plan[p].erd);
        check($sformatf("plan%0d_%0d_err", i, p), 32'(er), 32'(plan[p].eer));
      end
    end

    // Held req_valid: back-to-back loads, one accept per WAIT_CYCLES+2 cycles.
    req_we[0] = 1'b0; req_addr[0] = 32'h10; req_funct3[0] = F3_W; req_valid[0] = 1'b1;
    na = 0; nr = 0; acc[0] = 0; acc[1] = 0;
    for (int t = 0; t < 14; t++) begin
      if (na == 2) req_valid[0] = 1'b0;
      if (rsp_valid[0]) begin
        nr++;
        check("held_rdata", rsp_rdata[0], 32'h80ADBEEF);
      end
      if (req_valid[0] && req_ready[0]) begin
        if (na < 2) acc[na] = t;
        na++;
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    check("held_accepts", 32'(na), 32'd2);
    check("held_gap", 32'(acc[1] - acc[0]), 32'd4);
    check("held_rsps", 32'(nr), 32'd2);

    // Reset in the first BUSY cycle aborts the store.
    run_model(0, 1'b1, 32'h20, 32'h0, F3_W);
    req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    req_funct3[0] = F3_W; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    check("abort_ready_in_rst", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0; back = -1;
    for (int t = 0; t < 8; t++) begin
      if (rsp_valid[0]) seen = 1'b1;
      if (req_ready[0] && back < 0) back = t;
      @(negedge clk);
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    check("abort_ready_back", 32'((back >= 0) && (back <= 1)), 32'd1);
    do_req(0, 1'b0, 32'h20, 32'h0, F3_W, rd, er);
    check("abort_lw_rdata", rd, 32'h0);
    check("abort_lw_err", 32'(er), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 17; w++)
        run_model(i, 1'b1, (w == 16) ? 32'h3FC : 32'(w*4), $urandom, F3_W);
      for (int n = 0; n < 120; n++) begin
        logic [31:0] addr;
        case ($urandom_range(0, 5))
          0, 1, 2: addr = 32'($urandom_range(0, 63));
          3:       addr = 32'h3FC + 32'($urandom_range(0, 3));
          4:       addr = 32'h400 + 32'($urandom_range(0, 15));
          default: addr = $urandom | 32'h8000_0000;
        endcase
        run_model(i, 1'($urandom_range(0, 1)), addr, $urandom, 3'($urandom_range(0, 7)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port; it is the other end of the core's data-memory interface.
- Accepts one request at a time over a valid/ready handshake and models configurable wait states.
- Performs byte/halfword/word stores and sign- or zero-extended loads, encoded by RISC-V funct3.
- Flags misaligned, illegal or out-of-range accesses with an error response.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words of storage; word index = req_addr[31:2].
- WAIT_CYCLES, 2: BUSY cycles between accept and response; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_funct3  in  3  access size/sign (RISC-V load/store funct3)
- req_ready  out  1  responder can accept; high only in IDLE and not in reset
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  valid only with rsp_valid

Behaviour:
- Clock, reset and polarity are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 while rst=1.
  - Storage array is not cleared.
- FSM IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: accept on req_valid && req_ready at a rising edge; latch we/addr/wdata/funct3.
  - After accept, go to BUSY with counter=WAIT_CYCLES-1; if WAIT_CYCLES=0, go straight to RESP.
  - BUSY: decrement the counter each cycle; at 0, transition to RESP.
  - RESP: exactly one cycle with rsp_valid=1, then IDLE.
- Latency and throughput:
  - Accept at edge N gives rsp_valid high during cycle N+WAIT_CYCLES+1.
  - Peak throughput is one request per WAIT_CYCLES+2 cycles.
  - No accept in BUSY or RESP; a held req_valid waits for IDLE.
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected halfword.
  - Byte lane = addr[1:0]; halfword lane = addr[1]; little-endian.
- Stores:
  - 000 SB, 001 SH, 010 SW; only the addressed lanes change.
  - The write commits at the edge entering RESP.
- Errors, which set rsp_err=1, rsp_rdata=0 and suppress any write:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 011, 110 or 111;
  - store funct3 other than 000, 001 or 010;
  - addr[31:2] >= DEPTH_WORDS.
- Reset mid-operation:
  - rst in BUSY aborts the request: no write, no rsp_valid.
  - A write already committed on entering RESP stays.
- rsp_rdata and rsp_err are registered and hold their value until the next RESP.
  - The bench checks them only with rsp_valid.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - state enum IDLE/BUSY/RESP.
- One sub-module, dmem_lane_align (combinational):
  - store side: from wdata, funct3 and addr[1:0], produces a 4-bit byte-enable and the lane-shifted write word;
  - load side: from the read word, funct3 and addr[1:0], produces the extended rdata;
  - also produces a misalign/illegal flag.

Test Plan (WAIT_CYCLES=2, DEPTH_WORDS=256):
- SW 0xDEADBEEF @0x10 accepted at edge 0 -> req_ready=0 for cycles 1-3, rsp_valid in cycle 3, err=0.
  - Then LW @0x10 -> rsp_rdata=0xDEADBEEF.
- SB 0x80 @0x13 after the previous step:
  - LW @0x10 -> 0x80ADBEEF;
  - LB @0x13 -> 0xFFFFFF80;
  - LBU @0x13 -> 0x00000080;
  - LH @0x12 -> 0xFFFF80AD;
  - LHU @0x10 -> 0x0000BEEF.
- LH @0x11 -> err=1, rdata=0. SW 0x11111111 @0x12 -> err=1; then LW @0x10 is still 0x80ADBEEF.
  - LW with funct3=011 -> err=1.
  - LW @0x400 -> err=1 (index 256 is out of range).
- req_valid held high across two requests -> second accept occurs 4 cycles after the first.
  - Exactly one rsp_valid per request; no acceptance while BUSY or RESP.
- SW 0x0 @0x20 completes, then SW 0x12345678 @0x20 with rst pulsed in the first BUSY cycle:
  - no rsp_valid; req_ready returns the cycle after rst drops;
  - LW @0x20 -> 0x00000000.
- Rerun the first and third scenarios with WAIT_CYCLES=0 -> rsp_valid in the cycle immediately after accept; same data and error results.
